// File: rtl/fifo_hex_overlay.sv
// fifo_hex_overlay
//   Text overlay that renders the live contents of a ufifo as rows of hex
//   numbers, head entry first. Sits between the VGA timing generator and the
//   RGB mux. Each FIFO entry occupies a slot of 2**SLOT_LG character cells.
//   The leftmost DIGITS cells of a slot hold the hex digits, MSB nibble first.
//   The remaining cells of the slot are blank.
//
// Ports
//   i_clk, i_rst       pixel clock, asynchronous active-high reset
//   i_px_x, i_px_y     current pixel coordinates
//   i_frame_tick       one pulse per frame; advances the blink counter
//   o_dmp_pos          FIFO dump position (valid one cycle after the pixel)
//   i_dmp_data/valid   combinational FIFO answer for o_dmp_pos
//   o_rom_addr         font ROM address {char, glyph row}
//   o_rom_bit          glyph column, bit 7 is the leftmost pixel
//   i_rom_data         font pixel, one cycle after the address
//   o_on, o_rgb        overlay-active flag and colour, 4 clocks after the pixel
module fifo_hex_overlay #(
    parameter int         DATA_W   = 8,
    parameter int         LGFLEN   = 5,
    parameter int         PL_LG    = 4,
    parameter int         SLOT_LG  = 2,
    parameter int         ORG_C    = 8,
    parameter int         ORG_R    = 1,
    parameter logic [2:0] FG_RGB   = 3'b001,
    parameter logic [2:0] BG_RGB   = 3'b110,
    parameter logic [2:0] HEAD_RGB = 3'b100,
    parameter int         BLINK_LG = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [9:0]        i_px_x,
    input  logic [9:0]        i_px_y,
    input  logic              i_frame_tick,
    output logic [LGFLEN-1:0] o_dmp_pos,
    input  logic [DATA_W-1:0] i_dmp_data,
    input  logic              i_dmp_valid,
    output logic [10:0]       o_rom_addr,
    output logic [2:0]        o_rom_bit,
    input  logic              i_rom_data,
    output logic              o_on,
    output logic [2:0]        o_rgb
);

    localparam int DIGITS   = DATA_W / 4;
    localparam int DEPTH    = 1 << LGFLEN;
    localparam int PER_LINE = 1 << PL_LG;
    localparam int LINES    = (DEPTH + PER_LINE - 1) / PER_LINE;
    localparam int COLS     = PER_LINE << SLOT_LG;

    // ---------------- S0: pixel capture ----------------
    logic [9:0] x0, y0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x0 <= '0;
            y0 <= '0;
        end else begin
            x0 <= i_px_x;
            y0 <= i_px_y;
        end
    end

    // ---------------- cell decode ----------------
    // Arithmetic is done 32 bits wide so that pixels left of / above the
    // origin wrap to huge values and fall out of the range compares.
    logic [31:0]        c, r, rc, rr, slot, pos_full;
    logic [SLOT_LG-1:0] d;
    logic               in_reg, pos_ok, show;
    logic [3:0]         nib;
    logic [7:0]         ch;

    assign c        = {25'd0, x0[9:3]};
    assign r        = {25'd0, y0[9:3]};
    assign rc       = c - 32'(ORG_C);
    assign rr       = r - 32'(ORG_R);
    assign in_reg   = (c >= 32'(ORG_C)) && (rc < 32'(COLS)) &&
                      (r >= 32'(ORG_R)) && (rr < 32'(LINES));
    assign slot     = rc >> SLOT_LG;
    assign d        = rc[SLOT_LG-1:0];
    assign pos_full = (rr << PL_LG) + slot;
    assign pos_ok   = pos_full < 32'(DEPTH);
    assign o_dmp_pos = pos_full[LGFLEN-1:0];

    // Cell d shows nibble DIGITS-1-d so the MSB nibble lands leftmost.
    always_comb begin
        nib = '0;
        for (int k = 0; k < DIGITS; k++)
            if (32'(d) == 32'(DIGITS - 1 - k))
                nib = i_dmp_data[k*4 +: 4];
    end

    assign show = in_reg && pos_ok && i_dmp_valid && (32'(d) < 32'(DIGITS));

    always_comb begin
        ch = 8'h00;
        if (show)
            ch = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    end

    // ---------------- S1: char / glyph coordinates ----------------
    logic [7:0] char1;
    logic [2:0] row1, bit1;
    logic       show1, on1, head1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            char1 <= '0;
            row1  <= '0;
            bit1  <= '0;
            show1 <= 1'b0;
            on1   <= 1'b0;
            head1 <= 1'b0;
        end else begin
            char1 <= ch;
            row1  <= y0[2:0];
            bit1  <= x0[2:0];
            show1 <= show;
            on1   <= in_reg;
            head1 <= (o_dmp_pos == '0);
        end
    end

    assign o_rom_addr = {char1, row1};
    assign o_rom_bit  = ~bit1;

    // ---------------- S2: align flags with the ROM read ----------------
    logic show2, on2, head2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            show2 <= 1'b0;
            on2   <= 1'b0;
            head2 <= 1'b0;
        end else begin
            show2 <= show1;
            on2   <= on1;
            head2 <= head1;
        end
    end

    // ---------------- blink phase ----------------
    logic [BLINK_LG-1:0] blink_cnt;
    logic                blink;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            blink_cnt <= '0;
        else if (i_frame_tick)
            blink_cnt <= blink_cnt + 1'b1;
    end

    assign blink = blink_cnt[BLINK_LG-1];

    // ---------------- S3: output colour ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_on  <= 1'b0;
            o_rgb <= '0;
        end else begin
            o_on <= on2;
            if (!show2 || !i_rom_data)
                o_rgb <= BG_RGB;
            else if (head2 && blink)
                o_rgb <= HEAD_RGB;
            else
                o_rgb <= FG_RGB;
        end
    end

endmodule

// File: tb/tb_fifo_hex_overlay.sv
module tb_fifo_hex_overlay;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] px_x, px_y;
    logic       tick;

    // unit 0: default parameters; unit 1: DATA_W=16, LGFLEN=3, PL_LG=2, SLOT_LG=3
    logic [4:0]  pos1;
    logic [7:0]  data1;
    logic        val1, rd1, on1;
    logic [10:0] addr1;
    logic [2:0]  rbit1, rgb1;

    logic [2:0]  pos2;
    logic [15:0] data2;
    logic        val2, rd2, on2;
    logic [10:0] addr2;
    logic [2:0]  rbit2, rgb2;

    always #5 clk = ~clk;

    fifo_hex_overlay u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_px_x(px_x), .i_px_y(px_y), .i_frame_tick(tick),
        .o_dmp_pos(pos1), .i_dmp_data(data1), .i_dmp_valid(val1),
        .o_rom_addr(addr1), .o_rom_bit(rbit1), .i_rom_data(rd1),
        .o_on(on1), .o_rgb(rgb1)
    );

    fifo_hex_overlay #(.DATA_W(16), .LGFLEN(3), .PL_LG(2), .SLOT_LG(3)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_px_x(px_x), .i_px_y(px_y), .i_frame_tick(tick),
        .o_dmp_pos(pos2), .i_dmp_data(data2), .i_dmp_valid(val2),
        .o_rom_addr(addr2), .o_rom_bit(rbit2), .i_rom_data(rd2),
        .o_on(on2), .o_rgb(rgb2)
    );

    // ---------------- environment: FIFO dump port and font ROM ----------------
    logic [15:0] mem [2][32];
    int          cnt [2];
    bit          rom_force;
    int          ticks;

    function automatic logic font(input logic [10:0] a, input logic [2:0] b);
        logic [13:0] k;
        k = {a, b};
        return k[0] ^ k[4] ^ k[7] ^ k[11] ^ k[13] ^ (k[3] & k[9]);
    endfunction

    always_comb begin
        data1 = mem[0][pos1][7:0];
        val1  = 32'(pos1) < cnt[0];
        data2 = mem[1][{2'b00, pos2}];
        val2  = 32'(pos2) < cnt[1];
    end

    always_ff @(posedge clk) begin
        rd1 <= rom_force ? 1'b1 : font(addr1, rbit1);
        rd2 <= rom_force ? 1'b1 : font(addr2, rbit2);
    end

    // ---------------- reference model ----------------
    function automatic int dw(input int u);  return u ? 16 : 8; endfunction
    function automatic int lg(input int u);  return u ? 3 : 5;  endfunction
    function automatic int plg(input int u); return u ? 2 : 4;  endfunction
    function automatic int slg(input int u); return u ? 3 : 2;  endfunction

    function automatic void model(input int u, input int x, input int y,
                                  output bit on, output logic [2:0] rgb,
                                  output int pos, output logic [7:0] ch);
        int  c, r, rc, rr, dig, per, cols, depth, lines, slot, d, nib;
        bit  show, px, blink;
        c = x / 8;  r = y / 8;  rc = c - 8;  rr = r - 1;
        dig = dw(u) / 4;  per = 1 << plg(u);  cols = per << slg(u);
        depth = 1 << lg(u);  lines = (depth + per - 1) / per;
        on = (rc >= 0) && (rc < cols) && (rr >= 0) && (rr < lines);
        ch = 8'h00;  pos = 0;  show = 0;
        if (on) begin
            slot = rc / (1 << slg(u));
            d    = rc % (1 << slg(u));
            pos  = rr * per + slot;
            if (pos < depth && pos < cnt[u] && d < dig) begin
                nib  = (int'(mem[u][pos]) >> (4 * (dig - 1 - d))) & 15;
                ch   = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
                show = 1;
            end
        end
        px    = rom_force ? 1'b1 : font({ch, 3'(y % 8)}, 3'(7 - x % 8));
        blink = (ticks % 32) >= 16;
        rgb   = !show ? 3'b110 : !px ? 3'b110 : (pos == 0 && blink) ? 3'b100 : 3'b001;
    endfunction

    // ---------------- checking ----------------
    int n_vec = 0, n_err = 0, fg_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    bit         e_v   [4];
    bit         e_on  [2][4];
    logic [2:0] e_rgb [2][4];
    int         e_x   [4], e_y [4];

    task automatic clr();
        for (int i = 0; i < 4; i++) e_v[i] = 0;
    endtask

    // Drive one pixel per clock; outputs seen at a negedge belong to the
    // pixel driven four negedges earlier.
    task automatic step(input int x, input int y);
        bit         o;
        logic [2:0] g;
        int         p;
        logic [7:0] ch;
        @(negedge clk);
        if (e_v[3]) begin
            chk($sformatf("on u0 (%0d,%0d)", e_x[3], e_y[3]), int'(on1), int'(e_on[0][3]));
            chk($sformatf("rgb u0 (%0d,%0d)", e_x[3], e_y[3]), int'(rgb1), int'(e_rgb[0][3]));
            chk($sformatf("on u1 (%0d,%0d)", e_x[3], e_y[3]), int'(on2), int'(e_on[1][3]));
            chk($sformatf("rgb u1 (%0d,%0d)", e_x[3], e_y[3]), int'(rgb2), int'(e_rgb[1][3]));
        end
        if (on1 && rgb1 != 3'b110) fg_seen++;
        if (on2 && rgb2 != 3'b110) fg_seen++;
        for (int i = 3; i > 0; i--) begin
            e_v[i] = e_v[i-1];  e_x[i] = e_x[i-1];  e_y[i] = e_y[i-1];
            for (int u = 0; u < 2; u++) begin
                e_on[u][i]  = e_on[u][i-1];
                e_rgb[u][i] = e_rgb[u][i-1];
            end
        end
        px_x = 10'(x);  px_y = 10'(y);
        for (int u = 0; u < 2; u++) begin
            model(u, x, y, o, g, p, ch);
            e_on[u][0] = o;  e_rgb[u][0] = g;
        end
        e_v[0] = 1;  e_x[0] = x;  e_y[0] = y;
    endtask

    task automatic drain();
        repeat (4) step(0, 0);
        clr();
    endtask

    task automatic pulse_ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
        ticks += n;
    endtask

    typedef struct {
        int         u;
        int         x, y;
        bit         on;
        int         pos;
        logic [7:0] ch;
        logic [2:0] rgb;
    } vec_t;

    vec_t vecs [22];

    task automatic run_vec(input vec_t v);
        string tag;
        tag = $sformatf("u%0d (%0d,%0d)", v.u, v.x, v.y);
        @(negedge clk);
        px_x = 10'(v.x);  px_y = 10'(v.y);
        @(posedge clk); #1;
        if (v.on) chk({"dmp_pos ", tag}, v.u ? int'(pos2) : int'(pos1), v.pos);
        @(posedge clk); #1;
        chk({"rom_char ", tag}, v.u ? int'(addr2[10:3]) : int'(addr1[10:3]), int'(v.ch));
        chk({"rom_row ", tag},  v.u ? int'(addr2[2:0]) : int'(addr1[2:0]), v.y % 8);
        chk({"rom_bit ", tag},  v.u ? int'(rbit2) : int'(rbit1), 7 - v.x % 8);
        @(posedge clk); @(posedge clk); #1;
        chk({"on ", tag},  v.u ? int'(on2) : int'(on1), int'(v.on));
        chk({"rgb ", tag}, v.u ? int'(rgb2) : int'(rgb1), int'(v.rgb));
    endtask

    initial begin
        vecs[0]  = '{0,  64,  8, 1,  0, 8'h33, 3'd1};
        vecs[1]  = '{0,  72,  8, 1,  0, 8'h41, 3'd1};
        vecs[2]  = '{0,  80,  8, 1,  0, 8'h00, 3'd6};
        vecs[3]  = '{0,  96, 16, 1, 17, 8'h46, 3'd1};
        vecs[4]  = '{0, 104, 16, 1, 17, 8'h30, 3'd1};
        vecs[5]  = '{0, 112, 16, 1, 17, 8'h00, 3'd6};
        vecs[6]  = '{0, 192,  8, 1,  4, 8'h35, 3'd1};
        vecs[7]  = '{0, 200,  8, 1,  4, 8'h43, 3'd1};
        vecs[8]  = '{0, 300, 16, 1, 23, 8'h00, 3'd6};
        vecs[9]  = '{0, 575, 23, 1, 31, 8'h00, 3'd6};
        vecs[10] = '{0,  63,  8, 0,  0, 8'h00, 3'd6};
        vecs[11] = '{0, 576,  8, 0,  0, 8'h00, 3'd6};
        vecs[12] = '{0,  64, 24, 0,  0, 8'h00, 3'd6};
        vecs[13] = '{0,  64,  7, 0,  0, 8'h00, 3'd6};
        vecs[14] = '{1, 128, 16, 1,  5, 8'h42, 3'd1};
        vecs[15] = '{1, 136, 16, 1,  5, 8'h45, 3'd1};
        vecs[16] = '{1, 144, 16, 1,  5, 8'h45, 3'd1};
        vecs[17] = '{1, 152, 16, 1,  5, 8'h46, 3'd1};
        vecs[18] = '{1, 160, 16, 1,  5, 8'h00, 3'd6};
        vecs[19] = '{1, 192, 16, 1,  6, 8'h00, 3'd6};
        vecs[20] = '{1, 256, 16, 1,  7, 8'h00, 3'd6};
        vecs[21] = '{1, 320, 16, 0,  0, 8'h00, 3'd6};

        rst = 1'b1;  tick = 1'b0;  px_x = '0;  px_y = '0;
        rom_force = 1'b1;  ticks = 0;  clr();
        for (int u = 0; u < 2; u++) begin
            cnt[u] = 0;
            for (int i = 0; i < 32; i++) mem[u][i] = 16'($urandom);
        end

        // reset state
        repeat (2) @(posedge clk); #1;
        chk("reset on",      int'(on1),   0);
        chk("reset rgb",     int'(rgb1),  0);
        chk("reset rom_adr", int'(addr1), 0);
        chk("reset rom_bit", int'(rbit1), 7);
        @(negedge clk) rst = 1'b0;

        // directed vectors
        mem[0][0] = 16'h003A;  mem[0][4] = 16'h005C;  mem[0][17] = 16'h00F0;
        cnt[0] = 18;
        mem[1][5] = 16'hBEEF;  cnt[1] = 6;
        foreach (vecs[i]) run_vec(vecs[i]);

        // blink on the head entry
        @(negedge clk);  px_x = 10'd64;  px_y = 10'd8;
        repeat (4) @(posedge clk); #1;
        chk("blink 0 ticks", int'(rgb1), 1);
        pulse_ticks(15);
        repeat (4) @(posedge clk); #1;
        chk("blink 15 ticks", int'(rgb1), 1);
        pulse_ticks(1);
        repeat (4) @(posedge clk); #1;
        chk("blink 16 ticks", int'(rgb1), 4);
        pulse_ticks(16);
        repeat (4) @(posedge clk); #1;
        chk("blink 32 ticks", int'(rgb1), 1);

        // empty FIFO scan over the rows around the region
        cnt[0] = 0;  cnt[1] = 0;  clr();
        repeat (4) step(0, 0);
        fg_seen = 0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 640; x++) step(x, y);
        drain();
        chk("empty fg pixels", fg_seen, 0);

        // randomized rounds against the model
        for (int rnd = 0; rnd < 8; rnd++) begin
            clr();
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 32; i++) mem[u][i] = 16'($urandom);
                cnt[u] = int'($urandom_range(0, 1 << lg(u)));
            end
            if (rnd == 0) mem[0][0] = 16'h00FF;
            rom_force = (rnd % 3 == 0);
            pulse_ticks(int'($urandom_range(0, 20)));
            for (int n = 0; n < 600; n++)
                step(int'($urandom_range(0, 639)), int'($urandom_range(0, 40)));
            drain();
        end

        // reset in the middle of a line
        clr();
        rom_force = 1'b1;  mem[0][0] = 16'h003A;  cnt[0] = 18;
        step(64, 8);  step(100, 16);  step(64, 8);
        @(posedge clk); #2;
        rst = 1'b1;  ticks = 0;
        #1;
        chk("midrst on",      int'(on1),   0);
        chk("midrst rgb",     int'(rgb1),  0);
        chk("midrst rom_bit", int'(rbit1), 7);
        chk("midrst rom_adr", int'(addr1), 0);
        @(negedge clk);
        rst = 1'b0;  px_x = 10'd64;  px_y = 10'd8;
        repeat (3) @(posedge clk); #1;
        chk("post-rst 3 clk on", int'(on1), 0);
        @(posedge clk); #1;
        chk("post-rst 4 clk on",  int'(on1),  1);
        chk("post-rst 4 clk rgb", int'(rgb1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
